// File: rtl/ddr_pkg.sv
// ddr_pkg
// Shared definitions for the MIG user-interface arbiter: arbiter state
// encoding, MIG app_cmd opcodes and the default geometry parameters.
package ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD       = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    localparam int DEF_ADDR_W    = 25;
    localparam int DEF_LEN_W     = 16;
    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_STEP = 8;

endpackage

// File: rtl/ddr_burst_cnt.sv
// ddr_burst_cnt
// Loadable beat counter with a compare against the burst length.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count at zero (new burst granted)
//   inc       : one beat completed this cycle
//   len       : burst length in beats
//   hit       : count already equals len (burst complete)
//   hit_next  : count equals len after this cycle's increment
module ddr_burst_cnt
    import ddr_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             hit,
    output logic             hit_next
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    // inc is only asserted while count < len, so count + 1 never wraps here.
    assign hit      = (count == len);
    assign hit_next = hit || (inc && ((count + LEN_W'(1)) == len));

endmodule

// File: rtl/ddr_app_arbiter.sv
// ddr_app_arbiter
// Owns the MIG app_* interface and shares it round-robin between one write
// requester and one read requester, expanding each granted request into a
// burst of 128-bit app commands at consecutive addresses.
// Ports:
//   ui_clk, ui_clk_sync_rst       : MIG user clock, synchronous active-high reset
//   init_calib_complete           : new grants are held off while low
//   wr_req/addr/len, wr_ack/done  : write request, one-cycle grant and completion
//   rd_req/addr/len, rd_ack/done  : read request, one-cycle grant and completion
//   wr_data/mask/dvalid, wr_dready: write beat stream (mask 1 = byte masked)
//   rd_data, rd_dvalid            : returned read beats
//   app_*                         : MIG user interface
module ddr_app_arbiter
    import ddr_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,

    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [LEN_W-1:0]    wr_len,
    output logic                wr_ack,
    output logic                wr_done,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_mask,
    input  logic                wr_dvalid,
    output logic                wr_dready,

    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [LEN_W-1:0]    rd_len,
    output logic                rd_ack,
    output logic                rd_done,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_dvalid,

    output logic [27:0]         app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    input  logic                app_rd_data_valid,
    input  logic [DATA_W-1:0]   app_rd_data
);

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic               last_wr;

    logic grant_wr, grant_rd;
    logic set_wr_done, set_rd_done;
    logic issue_inc, issue_hit, issue_hit_next;
    logic ret_inc, ret_hit, ret_hit_next;
    logic in_wr, in_rd, in_rx, wr_beat;

    ddr_burst_cnt #(.LEN_W(LEN_W)) u_issue_cnt (
        .clk      (ui_clk),
        .rst      (ui_clk_sync_rst),
        .clr      (grant_wr || grant_rd),
        .inc      (issue_inc),
        .len      (len_q),
        .hit      (issue_hit),
        .hit_next (issue_hit_next)
    );

    ddr_burst_cnt #(.LEN_W(LEN_W)) u_ret_cnt (
        .clk      (ui_clk),
        .rst      (ui_clk_sync_rst),
        .clr      (grant_wr || grant_rd),
        .inc      (ret_inc),
        .len      (len_q),
        .hit      (ret_hit),
        .hit_next (ret_hit_next)
    );

    // Datapath decode. Kept apart from the next-state process because the
    // counters' hit_next depends on issue_inc/ret_inc.
    assign in_wr = (state == ST_WR);
    assign in_rd = (state == ST_RD);
    assign in_rx = (state == ST_RD) || (state == ST_RD_DRAIN);

    // Command and write data always go out together in a write burst.
    assign wr_beat      = in_wr && wr_dvalid && !issue_hit;
    assign app_en       = wr_beat || (in_rd && !issue_hit);
    assign app_wdf_wren = wr_beat;
    assign app_wdf_end  = wr_beat;
    assign app_cmd      = in_rx ? APP_CMD_RD : APP_CMD_WR;
    assign app_addr     = {{(28-ADDR_W){1'b0}}, addr_q};
    assign app_wdf_data = wr_data;
    assign app_wdf_mask = wr_mask;

    assign issue_inc = app_en && app_rdy && (in_rd || app_wdf_rdy);
    assign wr_dready = in_wr && issue_inc;

    // Returns outside a read burst (e.g. left over from before a reset) are dropped.
    assign rd_data   = app_rd_data;
    assign rd_dvalid = in_rx && app_rd_data_valid;
    assign ret_inc   = rd_dvalid;

    always_comb begin
        state_next  = state;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        set_wr_done = 1'b0;
        set_rd_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A pending done pulse marks the cycle right after a burst;
                // holding off here guarantees one quiet IDLE cycle afterwards.
                if (init_calib_complete && !wr_done && !rd_done) begin
                    if (wr_req && (!rd_req || !last_wr)) begin
                        grant_wr   = 1'b1;
                        state_next = ST_WR;
                    end else if (rd_req) begin
                        grant_rd   = 1'b1;
                        state_next = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (issue_hit_next) begin
                    set_wr_done = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_RD: begin
                if (ret_hit_next) begin
                    set_rd_done = 1'b1;
                    state_next  = ST_IDLE;
                end else if (issue_hit_next) begin
                    state_next = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                if (ret_hit_next) begin
                    set_rd_done = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            last_wr <= 1'b0;
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            state   <= state_next;
            wr_ack  <= grant_wr;
            rd_ack  <= grant_rd;
            wr_done <= set_wr_done;
            rd_done <= set_rd_done;
            if (grant_wr) begin
                addr_q  <= wr_addr;
                len_q   <= wr_len;
                last_wr <= 1'b1;
            end else if (grant_rd) begin
                addr_q  <= rd_addr;
                len_q   <= rd_len;
                last_wr <= 1'b0;
            end else if (issue_inc) begin
                // Wraps modulo 2^ADDR_W by register width.
                addr_q <= addr_q + ADDR_W'(ADDR_STEP);
            end
        end
    end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
module tb_ddr_app_arbiter;
    localparam int ADDR_W = 25;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 128;

    logic                ui_clk = 1'b0;
    logic                ui_clk_sync_rst;
    logic                init_calib_complete;
    logic                wr_req, rd_req;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [LEN_W-1:0]    wr_len, rd_len;
    logic                wr_ack, wr_done, rd_ack, rd_done;
    logic [DATA_W-1:0]   wr_data, rd_data;
    logic [DATA_W/8-1:0] wr_mask;
    logic                wr_dvalid, wr_dready, rd_dvalid;
    logic [27:0]         app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_wren, app_wdf_end;
    logic                app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [DATA_W-1:0]   app_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 ui_clk = ~ui_clk;

    ddr_app_arbiter dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .wr_req              (wr_req),
        .wr_addr             (wr_addr),
        .wr_len              (wr_len),
        .wr_ack              (wr_ack),
        .wr_done             (wr_done),
        .wr_data             (wr_data),
        .wr_mask             (wr_mask),
        .wr_dvalid           (wr_dvalid),
        .wr_dready           (wr_dready),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_len              (rd_len),
        .rd_ack              (rd_ack),
        .rd_done             (rd_done),
        .rd_data             (rd_data),
        .rd_dvalid           (rd_dvalid),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data         (app_rd_data)
    );

    task automatic cyc();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic rdy_t   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic dv_t    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic en_t    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic rdyo_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [27:0] ad_t [7] = '{28'h500, 28'h508, 28'h508, 28'h508, 28'h510, 28'h510, 28'h510};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepts;
        logic exp_w;

        ui_clk_sync_rst = 1'b1;
        init_calib_complete = 1'b0;
        wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        wr_data = '0; wr_mask = '0; wr_dvalid = 0;
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
        cyc(); cyc();

        // Reset state
        check("rst app_en", app_en, 0);
        check("rst app_addr", app_addr, 0);
        check("rst app_cmd", app_cmd, 3'b000);
        check("rst wr_ack", wr_ack, 0);
        check("rst rd_ack", rd_ack, 0);
        check("rst wr_done", wr_done, 0);
        check("rst rd_done", rd_done, 0);
        check("rst rd_dvalid", rd_dvalid, 0);
        check("rst wdf_wren", app_wdf_wren, 0);
        check("rst wr_dready", wr_dready, 0);

        ui_clk_sync_rst = 1'b0;
        init_calib_complete = 1'b1;
        app_rdy = 1; app_wdf_rdy = 1;
        cyc();

        // Single write, len 4 at 0x100
        wr_req = 1; wr_addr = 25'h100; wr_len = 4; wr_dvalid = 1;
        wr_data = 128'hDEADBEEF_00000001; wr_mask = 16'h00F0;
        settle();
        check("wr1 idle no app_en", app_en, 0);
        cyc();
        check("wr1 ack", wr_ack, 1);
        wr_req = 0;
        settle();
        check("wr1 wdf_data", app_wdf_data, 128'hDEADBEEF_00000001);
        check("wr1 wdf_mask", app_wdf_mask, 16'h00F0);
        for (int i = 0; i < 4; i++) begin
            check("wr1 app_en", app_en, 1);
            check("wr1 wdf_wren", app_wdf_wren, 1);
            check("wr1 wdf_end", app_wdf_end, 1);
            check("wr1 cmd", app_cmd, 3'b000);
            check("wr1 addr", app_addr, 28'h100 + 28'(8 * i));
            check("wr1 dready", wr_dready, 1);
            check("wr1 no done", wr_done, 0);
            if (i == 1) check("wr1 ack single", wr_ack, 0);
            cyc();
        end
        wr_dvalid = 0;
        settle();
        check("wr1 done", wr_done, 1);
        check("wr1 app_en off", app_en, 0);
        cyc();
        check("wr1 done pulse", wr_done, 0);

        // Read len 3 at 0x40 with 20-cycle return latency
        rd_req = 1; rd_addr = 25'h40; rd_len = 3;
        cyc();
        check("rd1 ack", rd_ack, 1);
        rd_req = 0;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("rd1 app_en", app_en, 1);
            check("rd1 cmd", app_cmd, 3'b001);
            check("rd1 addr", app_addr, 28'h40 + 28'(8 * i));
            check("rd1 no wren", app_wdf_wren, 0);
            cyc();
        end
        check("rd1 drain no app_en", app_en, 0);
        check("rd1 drain cmd", app_cmd, 3'b001);
        repeat (17) cyc();
        check("rd1 no early done", rd_done, 0);
        for (int i = 0; i < 3; i++) begin
            app_rd_data_valid = 1;
            app_rd_data = 128'hA000 + 128'(i);
            settle();
            check("rd1 dvalid", rd_dvalid, 1);
            check("rd1 data", rd_data, 128'hA000 + 128'(i));
            check("rd1 done wait", rd_done, 0);
            cyc();
        end
        app_rd_data_valid = 0;
        settle();
        check("rd1 done", rd_done, 1);
        check("rd1 dvalid off", rd_dvalid, 0);
        cyc();
        check("rd1 done pulse", rd_done, 0);

        // Contention: both requests held, four len-1 bursts
        wr_req = 1; rd_req = 1; wr_len = 1; rd_len = 1;
        wr_addr = 25'h200; rd_addr = 25'h300; wr_dvalid = 1;
        settle();
        for (int k = 0; k < 4; k++) begin
            exp_w = ((k % 2) == 0);
            n = 0;
            while (!(wr_ack || rd_ack) && n < 8) begin
                cyc();
                n++;
            end
            check("cont ack seen", wr_ack | rd_ack, 1);
            check("cont grant wr", wr_ack, exp_w);
            check("cont grant rd", rd_ack, !exp_w);
            if (wr_ack) begin
                check("cont wr addr", app_addr, 28'h200);
                cyc();
                check("cont wr done", wr_done, 1);
            end else if (rd_ack) begin
                check("cont rd addr", app_addr, 28'h300);
                check("cont rd cmd", app_cmd, 3'b001);
                cyc();
                app_rd_data_valid = 1;
                settle();
                cyc();
                app_rd_data_valid = 0;
                settle();
                check("cont rd done", rd_done, 1);
            end
        end
        wr_req = 0; rd_req = 0; wr_dvalid = 0;
        cyc(); cyc();

        // Backpressure: app_rdy stalls and wr_dvalid gaps, len 3 at 0x500
        wr_req = 1; wr_addr = 25'h500; wr_len = 3; wr_dvalid = 1; app_rdy = 1;
        cyc();
        check("bp ack", wr_ack, 1);
        wr_req = 0;
        accepts = 0;
        for (int i = 0; i < 7; i++) begin
            app_rdy = rdy_t[i];
            wr_dvalid = dv_t[i];
            settle();
            check("bp app_en", app_en, en_t[i]);
            check("bp addr", app_addr, ad_t[i]);
            check("bp dready", wr_dready, rdyo_t[i]);
            check("bp no done", wr_done, 0);
            if (wr_dready) accepts++;
            cyc();
        end
        wr_dvalid = 0; app_rdy = 1;
        settle();
        check("bp accepts", 32'(accepts), 32'd3);
        check("bp done", wr_done, 1);
        check("bp app_en off", app_en, 0);
        cyc(); cyc();

        // len 0: ack then done, no app_en
        wr_req = 1; wr_addr = 25'h600; wr_len = 0; wr_dvalid = 1;
        cyc();
        check("len0 ack", wr_ack, 1);
        check("len0 no app_en", app_en, 0);
        wr_req = 0;
        cyc();
        check("len0 done", wr_done, 1);
        check("len0 no app_en2", app_en, 0);
        cyc();
        check("len0 done pulse", wr_done, 0);
        cyc();

        // Address wrap
        wr_req = 1; wr_addr = 25'h1FFFFF8; wr_len = 2; wr_dvalid = 1;
        cyc();
        check("wrap ack", wr_ack, 1);
        wr_req = 0;
        settle();
        check("wrap addr0", app_addr, 28'h1FFFFF8);
        cyc();
        check("wrap addr1", app_addr, 28'h0000000);
        check("wrap app_en1", app_en, 1);
        cyc();
        check("wrap done", wr_done, 1);
        wr_dvalid = 0;
        cyc(); cyc();

        // No grant while calibration incomplete
        init_calib_complete = 0;
        wr_req = 1; wr_len = 0; wr_addr = 25'h700;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("calib no ack", wr_ack, 0);
            check("calib no app_en", app_en, 0);
        end
        init_calib_complete = 1;
        cyc();
        check("calib ack", wr_ack, 1);
        wr_req = 0;
        cyc(); cyc(); cyc();

        // Reset mid-read after 2 of 5 issues
        rd_req = 1; rd_addr = 25'h80; rd_len = 5; app_rdy = 1;
        cyc();
        check("rrst ack", rd_ack, 1);
        check("rrst addr0", app_addr, 28'h80);
        rd_req = 0;
        cyc();
        check("rrst addr1", app_addr, 28'h88);
        cyc();
        check("rrst addr2", app_addr, 28'h90);
        ui_clk_sync_rst = 1;
        app_rdy = 0;
        cyc();
        check("rrst app_en", app_en, 0);
        check("rrst app_addr", app_addr, 0);
        check("rrst app_cmd", app_cmd, 3'b000);
        check("rrst rd_ack", rd_ack, 0);
        check("rrst rd_done", rd_done, 0);
        ui_clk_sync_rst = 0;
        app_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            app_rd_data_valid = 1;
            app_rd_data = 128'hBAD0 + 128'(i);
            settle();
            check("rrst stray dvalid", rd_dvalid, 0);
            check("rrst stray done", rd_done, 0);
            check("rrst stray app_en", app_en, 0);
            cyc();
        end
        app_rd_data_valid = 0;
        settle();
        check("rrst final done", rd_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
